// File: rtl/sauria_job_sequencer.sv
// Job sequencer for SAURIA: queues job descriptors, writes the config words and the start register,
// waits for done and reports a completion record. Optional watchdog: define SAURIA_SEQ_TIMEOUT_EN.
module sauria_job_sequencer #(
  parameter int unsigned       NUM_CFG_WORDS  = 8,
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter logic [ADDR_W-1:0] CFG_BASE_ADDR  = '0,
  parameter logic [ADDR_W-1:0] START_ADDR     = ADDR_W'(32'h0000_0100),
  parameter int unsigned       QUEUE_DEPTH    = 2,
  parameter int unsigned       TIMEOUT_CYCLES = 1048576
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            job_valid_i,
  output logic                            job_ready_o,
  input  logic [NUM_CFG_WORDS*DATA_W-1:0] job_cfg_i,
  input  logic [7:0]                      job_id_i,
  output logic                            cfg_req_o,
  input  logic                            cfg_gnt_i,
  output logic                            cfg_we_o,
  output logic [ADDR_W-1:0]               cfg_addr_o,
  output logic [DATA_W-1:0]               cfg_wdata_o,
  input  logic                            cfg_rvalid_i,
  input  logic                            cfg_err_i,
  input  logic                            sauria_done_i,
  output logic                            cmpl_valid_o,
  input  logic                            cmpl_ready_i,
  output logic [7:0]                      cmpl_id_o,
  output logic [1:0]                      cmpl_status_o,
  output logic                            busy_o,
  output logic [$clog2(QUEUE_DEPTH):0]    queue_cnt_o
);

  localparam int unsigned CfgW = NUM_CFG_WORDS * DATA_W;
  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned KW   = (NUM_CFG_WORDS > 1) ? $clog2(NUM_CFG_WORDS) : 1;
  localparam logic [1:0]  StatOk      = 2'd0;
  localparam logic [1:0]  StatTimeout = 2'd1;
  localparam logic [1:0]  StatBusErr  = 2'd2;

  if (NUM_CFG_WORDS < 1 || QUEUE_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sauria_job_sequencer: invalid parameter values");
  end

  typedef enum logic [2:0] {
    StIdle, StCfgReq, StCfgRsp, StStartReq, StStartRsp, StWaitDone, StReport
  } state_e;

  state_e state_q;

  // Job queue
  logic [CfgW-1:0] q_cfg_q [QUEUE_DEPTH];
  logic [7:0]      q_id_q  [QUEUE_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ready_q;
  logic            push, pop;

  assign push = job_valid_i && ready_q;
  assign pop  = (state_q == StIdle) && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != CntW'(QUEUE_DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_cfg_q[wr_ptr_q] <= job_cfg_i;
      q_id_q[wr_ptr_q]  <= job_id_i;
    end
  end

  // Sequencer
  logic [CfgW-1:0]   job_cfg_q;
  logic [7:0]        job_id_q;
  logic [KW-1:0]     k_q, k_inc;
  logic              done_prev_q, done_flag_q, done_rise, done_armed;
  logic              cfg_req_q, cmpl_valid_q;
  logic [ADDR_W-1:0] cfg_addr_q;
  logic [DATA_W-1:0] cfg_wdata_q;
  logic [7:0]        cmpl_id_q;
  logic [1:0]        cmpl_status_q;
`ifdef SAURIA_SEQ_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TmrW-1:0] tmr_q;
`endif

  assign k_inc      = k_q + 1'b1;
  assign done_rise  = sauria_done_i && !done_prev_q;
  // Armed from START_RSP so a done coinciding with the start response is not lost.
  assign done_armed = (state_q == StStartRsp) || (state_q == StWaitDone);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      job_cfg_q     <= '0;
      job_id_q      <= '0;
      k_q           <= '0;
      done_prev_q   <= 1'b0;
      done_flag_q   <= 1'b0;
      cfg_req_q     <= 1'b0;
      cfg_addr_q    <= '0;
      cfg_wdata_q   <= '0;
      cmpl_valid_q  <= 1'b0;
      cmpl_id_q     <= '0;
      cmpl_status_q <= '0;
`ifdef SAURIA_SEQ_TIMEOUT_EN
      tmr_q         <= '0;
`endif
    end else begin
      done_prev_q <= sauria_done_i;
      if (done_armed && done_rise) done_flag_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (cnt_q != '0) begin
            job_cfg_q   <= q_cfg_q[rd_ptr_q];
            job_id_q    <= q_id_q[rd_ptr_q];
            k_q         <= '0;
            done_flag_q <= 1'b0;
            cfg_req_q   <= 1'b1;
            cfg_addr_q  <= CFG_BASE_ADDR;
            cfg_wdata_q <= q_cfg_q[rd_ptr_q][DATA_W-1:0];
            state_q     <= StCfgReq;
          end
        end
        StCfgReq, StStartReq: begin
          if (cfg_gnt_i) begin
            cfg_req_q <= 1'b0;
            state_q   <= (state_q == StCfgReq) ? StCfgRsp : StStartRsp;
          end
        end
        StCfgRsp: begin
          if (cfg_rvalid_i) begin
            if (cfg_err_i) begin
              cmpl_valid_q  <= 1'b1;
              cmpl_id_q     <= job_id_q;
              cmpl_status_q <= StatBusErr;
              state_q       <= StReport;
            end else if (k_q == KW'(NUM_CFG_WORDS - 1)) begin
              cfg_req_q   <= 1'b1;
              cfg_addr_q  <= START_ADDR;
              cfg_wdata_q <= DATA_W'(1);
              state_q     <= StStartReq;
            end else begin
              k_q         <= k_inc;
              cfg_req_q   <= 1'b1;
              cfg_addr_q  <= CFG_BASE_ADDR + (ADDR_W'(k_inc) << 2);
              cfg_wdata_q <= job_cfg_q[k_inc*DATA_W +: DATA_W];
              state_q     <= StCfgReq;
            end
          end
        end
        StStartRsp: begin
          if (cfg_rvalid_i) begin
            if (cfg_err_i) begin
              cmpl_valid_q  <= 1'b1;
              cmpl_id_q     <= job_id_q;
              cmpl_status_q <= StatBusErr;
              state_q       <= StReport;
            end else begin
`ifdef SAURIA_SEQ_TIMEOUT_EN
              tmr_q <= '0;
`endif
              state_q <= StWaitDone;
            end
          end
        end
        StWaitDone: begin
          if (done_flag_q || done_rise) begin
            cmpl_valid_q  <= 1'b1;
            cmpl_id_q     <= job_id_q;
            cmpl_status_q <= StatOk;
            state_q       <= StReport;
          end
`ifdef SAURIA_SEQ_TIMEOUT_EN
          else if (tmr_q == TmrW'(TIMEOUT_CYCLES - 1)) begin
            cmpl_valid_q  <= 1'b1;
            cmpl_id_q     <= job_id_q;
            cmpl_status_q <= StatTimeout;
            state_q       <= StReport;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
`endif
        end
        StReport: begin
          if (cmpl_ready_i) begin
            cmpl_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign job_ready_o   = ready_q;
  assign queue_cnt_o   = cnt_q;
  assign busy_o        = (state_q != StIdle);
  assign cfg_req_o     = cfg_req_q;
  assign cfg_we_o      = cfg_req_q;
  assign cfg_addr_o    = cfg_addr_q;
  assign cfg_wdata_o   = cfg_wdata_q;
  assign cmpl_valid_o  = cmpl_valid_q;
  assign cmpl_id_o     = cmpl_id_q;
  assign cmpl_status_o = cmpl_status_q;

endmodule

// File: tb/tb_sauria_job_sequencer.sv
// Scoreboard bench for sauria_job_sequencer: expected bus writes and completions are queued at
// push time and checked by a monitor whenever the DUT hands a write or a completion over.
module tb_sauria_job_sequencer;

  localparam int NW = 8;

  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  typedef struct {logic [7:0] id; logic [1:0] st;} cm_t;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            job_valid_i = 1'b0;
  logic            job_ready_o;
  logic [NW*32-1:0] job_cfg_i = '0;
  logic [7:0]      job_id_i = '0;
  logic            cfg_req_o, cfg_we_o;
  logic            cfg_gnt_i = 1'b0;
  logic [31:0]     cfg_addr_o, cfg_wdata_o;
  logic            cfg_rvalid_i = 1'b0;
  logic            cfg_err_i = 1'b0;
  logic            sauria_done_i = 1'b0;
  logic            cmpl_valid_o;
  logic            cmpl_ready_i = 1'b1;
  logic [7:0]      cmpl_id_o;
  logic [1:0]      cmpl_status_o;
  logic            busy_o;
  logic [1:0]      queue_cnt_o;

  sauria_job_sequencer #(
    .NUM_CFG_WORDS (NW),
    .QUEUE_DEPTH   (2),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .job_valid_i   (job_valid_i),
    .job_ready_o   (job_ready_o),
    .job_cfg_i     (job_cfg_i),
    .job_id_i      (job_id_i),
    .cfg_req_o     (cfg_req_o),
    .cfg_gnt_i     (cfg_gnt_i),
    .cfg_we_o      (cfg_we_o),
    .cfg_addr_o    (cfg_addr_o),
    .cfg_wdata_o   (cfg_wdata_o),
    .cfg_rvalid_i  (cfg_rvalid_i),
    .cfg_err_i     (cfg_err_i),
    .sauria_done_i (sauria_done_i),
    .cmpl_valid_o  (cmpl_valid_o),
    .cmpl_ready_i  (cmpl_ready_i),
    .cmpl_id_o     (cmpl_id_o),
    .cmpl_status_o (cmpl_status_o),
    .busy_o        (busy_o),
    .queue_cnt_o   (queue_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  wr_t exp_wr[$];
  cm_t exp_cm[$];

  // Bench-side knobs for the bus/SAURIA responder.
  logic [31:0] stall_addr = 32'hDEAD_BEEF;
  int          stall_left = 0;
  int          stall_seen = 0;
  logic [31:0] err_addr   = 32'hDEAD_BEEF;
  bit          err_armed  = 0;
  bit          gnt_block  = 0;
  bit          done_en    = 1;
  int          cmpl_block = 0;
  int          cmpl_wait  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [7:0] id, input int i);
    logic [7:0] iw;
    iw = 8'(i);
    return {id, 8'h00, iw, 8'hA5};
  endfunction

  // Push one job; err_word >= 0 means the slave will error that word's write.
  task automatic push_job(input logic [7:0] id, input int err_word, input logic [1:0] st);
    int n;
    wr_t w;
    cm_t c;
    for (int i = 0; i < NW; i++) job_cfg_i[i*32 +: 32] = word_of(id, i);
    job_id_i    = id;
    job_valid_i = 1'b1;
    n = 0;
    while (!job_ready_o && n < 2000) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!job_ready_o) begin
      chk("push_ready_timeout", 64'(job_ready_o), 64'd1);
      job_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i); #1;
    job_valid_i = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (err_word < 0 || i <= err_word) begin
        w.addr = 32'(4 * i);
        w.data = word_of(id, i);
        exp_wr.push_back(w);
      end
    end
    if (err_word < 0) begin
      w.addr = 32'h100;
      w.data = 32'd1;
      exp_wr.push_back(w);
    end
    c.id = id;
    c.st = st;
    exp_cm.push_back(c);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_cm.size() != 0 || busy_o) && n < 3000) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk({name, "_drain_writes_left"}, 64'(exp_wr.size()), 64'd0);
    chk({name, "_drain_cmpl_left"}, 64'(exp_cm.size()), 64'd0);
  endtask

  // Bus slave, done generator and completion sink, driven just after each rising edge.
  initial begin
    bit pend, pend_err;
    int done_cnt, start_idx;
    pend = 0; pend_err = 0; done_cnt = 0; start_idx = 0;
    forever begin
      @(posedge clk_i); #1;
      if (!rst_ni) begin
        pend = 0; pend_err = 0; done_cnt = 0;
        cfg_gnt_i = 0; cfg_rvalid_i = 0; cfg_err_i = 0; sauria_done_i = 0;
      end else begin
        cfg_rvalid_i = pend;
        cfg_err_i    = pend && pend_err;
        pend = 0; pend_err = 0;
        sauria_done_i = 1'b0;
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) sauria_done_i = 1'b1;
        end
        cfg_gnt_i = 1'b0;
        if (cfg_req_o && !gnt_block) begin
          if (stall_left > 0 && cfg_addr_o == stall_addr) begin
            stall_left--;
          end else begin
            cfg_gnt_i = 1'b1;
            pend = 1;
            if (err_armed && cfg_addr_o == err_addr) begin
              pend_err = 1;
              err_armed = 0;
            end
            if (cfg_addr_o == 32'h100) begin
              // Every third start gets done in the same cycle as its response.
              if (done_en) done_cnt = (start_idx % 3 == 2) ? 1 : 21;
              start_idx++;
            end
          end
        end
        cmpl_ready_i = 1'b1;
        if (cmpl_valid_o && cmpl_block > 0) begin
          cmpl_ready_i = 1'b0;
          cmpl_block--;
        end
      end
    end
  end

  // Monitor: pops and compares on each accepted write/completion, checks hold stability.
  initial begin
    bit hold_wr, hold_cm;
    logic [31:0] h_addr, h_data;
    logic [7:0]  h_id;
    logic [1:0]  h_st;
    wr_t w;
    cm_t c;
    hold_wr = 0; hold_cm = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        hold_wr = 0; hold_cm = 0;
      end else begin
        if (hold_wr) begin
          chk("req_held", 64'(cfg_req_o), 64'd1);
          chk("addr_stable", 64'(cfg_addr_o), 64'(h_addr));
          chk("wdata_stable", 64'(cfg_wdata_o), 64'(h_data));
        end
        if (cfg_req_o) chk("we_with_req", 64'(cfg_we_o), 64'd1);
        if (cfg_req_o && !cfg_gnt_i && cfg_addr_o == stall_addr) stall_seen++;
        hold_wr = cfg_req_o && !cfg_gnt_i;
        h_addr = cfg_addr_o;
        h_data = cfg_wdata_o;
        if (cfg_req_o && cfg_gnt_i) begin
          chk("write_expected", 64'(exp_wr.size() != 0), 64'd1);
          if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            chk("write_addr", 64'(cfg_addr_o), 64'(w.addr));
            chk("write_data", 64'(cfg_wdata_o), 64'(w.data));
          end
        end
        if (hold_cm) begin
          chk("cmpl_valid_held", 64'(cmpl_valid_o), 64'd1);
          chk("cmpl_id_stable", 64'(cmpl_id_o), 64'(h_id));
          chk("cmpl_status_stable", 64'(cmpl_status_o), 64'(h_st));
        end
        if (cmpl_valid_o) chk("no_bus_during_report", 64'(cfg_req_o), 64'd0);
        if (cmpl_valid_o && !cmpl_ready_i) cmpl_wait++;
        hold_cm = cmpl_valid_o && !cmpl_ready_i;
        h_id = cmpl_id_o;
        h_st = cmpl_status_o;
        if (cmpl_valid_o && cmpl_ready_i) begin
          chk("cmpl_expected", 64'(exp_cm.size() != 0), 64'd1);
          if (exp_cm.size() != 0) begin
            c = exp_cm.pop_front();
            chk("cmpl_id", 64'(cmpl_id_o), 64'(c.id));
            chk("cmpl_status", 64'(cmpl_status_o), 64'(c.st));
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_cfg_req", 64'(cfg_req_o), 64'd0);
    chk("rst_cmpl_valid", 64'(cmpl_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_queue_cnt", 64'(queue_cnt_o), 64'd0);
    chk("rst_addr_wdata", {cfg_addr_o, cfg_wdata_o}, 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("ready_after_reset", 64'(job_ready_o), 64'd1);

    // Single job: latency T+2, full write sequence, done 20 cycles after start response
    push_job(8'h5A, -1, 2'd0);
    chk("lat_req_t1", 64'(cfg_req_o), 64'd0);
    @(posedge clk_i); #1;
    chk("lat_req_t2", 64'(cfg_req_o), 64'd1);
    chk("lat_busy_t2", 64'(busy_o), 64'd1);
    chk("lat_addr_t2", 64'(cfg_addr_o), 64'h0);
    wait_drain("single");

    // Grant stalled 5 cycles on word 3
    stall_addr = 32'hC;
    stall_left = 5;
    stall_seen = 0;
    push_job(8'h11, -1, 2'd0);
    wait_drain("stall");
    chk("stall_cycles", 64'(stall_seen), 64'd5);
    stall_addr = 32'hDEAD_BEEF;

    // Error on word 2, next queued job runs normally
    err_addr  = 32'h8;
    err_armed = 1;
    push_job(8'h22, 2, 2'd2);
    push_job(8'h23, -1, 2'd0);
    wait_drain("buserr");

    // Three back-to-back pushes into a depth-2 queue
    push_job(8'h01, -1, 2'd0);
    push_job(8'h02, -1, 2'd0);
    chk("cnt_after_2", 64'(queue_cnt_o), 64'd1);
    chk("ready_after_2", 64'(job_ready_o), 64'd1);
    push_job(8'h03, -1, 2'd0);
    chk("cnt_full", 64'(queue_cnt_o), 64'd2);
    chk("ready_full", 64'(job_ready_o), 64'd0);
    wait_drain("b2b");
    chk("ready_drained", 64'(job_ready_o), 64'd1);

    // Completion back-pressure for 10 cycles with another job queued
    cmpl_block = 10;
    cmpl_wait  = 0;
    push_job(8'h77, -1, 2'd0);
    push_job(8'h78, -1, 2'd0);
    wait_drain("backpressure");
    chk("cmpl_wait_cycles", 64'(cmpl_wait), 64'd10);

`ifdef SAURIA_SEQ_TIMEOUT_EN
    done_en = 0;
    push_job(8'hE0, -1, 2'd1);
    wait_drain("timeout");
    done_en = 1;
`endif

    // Reset while a request is outstanding, with another job queued
    gnt_block = 1;
    push_job(8'h90, -1, 2'd0);
    push_job(8'h91, -1, 2'd0);
    n = 0;
    while (!cfg_req_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("midrst_req_seen", 64'(cfg_req_o), 64'd1);
    exp_wr.delete();
    exp_cm.delete();
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_cfg_req", 64'(cfg_req_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_queue_cnt", 64'(queue_cnt_o), 64'd0);
    chk("midrst_cmpl_valid", 64'(cmpl_valid_o), 64'd0);
    chk("midrst_addr_wdata", {cfg_addr_o, cfg_wdata_o}, 64'd0);
    gnt_block = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (30) @(posedge clk_i);
    #1;
    chk("post_rst_busy", 64'(busy_o), 64'd0);
    chk("post_rst_ready", 64'(job_ready_o), 64'd1);
    chk("post_rst_cnt", 64'(queue_cnt_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sauria_job_sequencer.md
Name: sauria_job_sequencer

Overview:
- Sequences SAURIA jobs inside the Cheshire-hosted SAURIA demonstrator.
- Accepts job descriptors (config word set plus job ID) from a host-side queue and writes the config words to SAURIA's config register file over a req/gnt/rvalid register bus.
- Writes the start register, waits for SAURIA's done interrupt, then reports a completion record with status.
- Sits between the Cheshire-side control path and the SAURIA config port, so software issues whole jobs instead of individual register writes.

Parameters:
- NUM_CFG_WORDS, 8, config words per job (≥1).
- ADDR_W, 32, config bus address width.
- DATA_W, 32, config bus data width.
- CFG_BASE_ADDR, 32'h0000_0000, address of config word 0; word i is at CFG_BASE_ADDR + 4*i.
- START_ADDR, 32'h0000_0100, start register address; the start write data is 1.
- QUEUE_DEPTH, 2, job queue entries (power of two, ≥2).
- TIMEOUT_CYCLES, 1048576, watchdog limit in WAIT_DONE (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- job_valid_i  in  1  descriptor valid.
- job_ready_o  out  1  queue not full.
- job_cfg_i  in  NUM_CFG_WORDS*DATA_W  config words; word 0 in the LSBs.
- job_id_i  in  8  job tag.
- cfg_req_o  out  1  bus request.
- cfg_gnt_i  in  1  bus grant.
- cfg_we_o  out  1  write enable (always 1 while requesting).
- cfg_addr_o  out  ADDR_W  bus address.
- cfg_wdata_o  out  DATA_W  bus write data.
- cfg_rvalid_i  in  1  write response.
- cfg_err_i  in  1  response error, qualified by rvalid.
- sauria_done_i  in  1  SAURIA done interrupt (level or pulse).
- cmpl_valid_o  out  1  completion valid.
- cmpl_ready_i  in  1  completion accept.
- cmpl_id_o  out  8  completed job tag.
- cmpl_status_o  out  2  0 OK, 1 TIMEOUT, 2 BUS_ERR.
- busy_o  out  1  FSM not in IDLE.
- queue_cnt_o  out  $clog2(QUEUE_DEPTH)+1  queued jobs.

Behaviour:
- Reset values:
  - All outputs 0, except job_ready_o = 1 after reset releases.
  - Queue is flushed and the FSM is in IDLE.
  - Reset asserted mid-operation aborts immediately: no completion is issued and cfg_req_o drops asynchronously.
- Queue:
  - Push when job_valid_i && job_ready_o; job_ready_o = !full, registered.
  - Push on a full queue is impossible by the handshake.
  - Pop occurs only on the IDLE→CFG_REQ transition; a simultaneous push and pop keeps the count unchanged.
- FSM states: IDLE, CFG_REQ, CFG_RSP, START_REQ, START_RSP, WAIT_DONE, REPORT.
- IDLE:
  - Stays while the queue is empty.
  - Otherwise pops the head into a job register, sets word index k=0, clears the done flag, and goes to CFG_REQ.
  - Latency: a push at cycle T into an empty queue with the FSM in IDLE gives cfg_req_o=1 at T+2.
- CFG_REQ:
  - cfg_req_o=1, addr=CFG_BASE_ADDR+4k, wdata=word k.
  - addr and wdata are held stable until cfg_gnt_i; on grant go to CFG_RSP.
- CFG_RSP:
  - Waits for cfg_rvalid_i; the earliest response is the cycle after the grant.
  - On rvalid with err: status=BUS_ERR, skip the remaining words and the start write, go to REPORT.
  - Otherwise: if k == NUM_CFG_WORDS-1 go to START_REQ, else k++ and go to CFG_REQ.
- START_REQ / START_RSP:
  - Same handshake as CFG_REQ/CFG_RSP, writing addr=START_ADDR, wdata=1.
  - Error → BUS_ERR, then REPORT.
  - OK → WAIT_DONE.
- Done flag:
  - Sticky; set on a rising edge of sauria_done_i, using a registered previous value.
  - Armed from entry to START_RSP, so a done arriving in the same cycle as the start response is captured.
  - Edges seen in any other state are ignored.
- WAIT_DONE: leaves when the done flag is set, with status=OK, and goes to REPORT.
- REPORT:
  - cmpl_valid_o=1 with id and status held stable until cmpl_ready_i.
  - On the handshake, goes to IDLE. The next job may start the following cycle (back-to-back).
- Config words are taken from the job register, not the queue, so later pushes do not corrupt a running job.

Optional Feature:
- Macro: SAURIA_SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_DONE and increments each cycle there.
  - Reaching TIMEOUT_CYCLES without done gives status=TIMEOUT and REPORT.
  - Done and timeout in the same cycle → OK.
- Undefined: no counter; WAIT_DONE waits indefinitely and status 1 is never produced.

Test Plan:
- Single job, NUM_CFG_WORDS=8, immediate gnt, rvalid one cycle later, done pulse 20 cycles after the start → 8 writes to 0x0,0x4..0x1C, one write of 1 to 0x100, then completion id=0x5A, status=0.
- Grant stalled 5 cycles on word 3 → addr 0xC and its wdata stable for all 6 cycles; exactly one write per word.
- cfg_err_i on word 2 → no further writes, no start write; completion status=2; the next queued job starts normally.
- Push 3 jobs back-to-back with QUEUE_DEPTH=2 while job 1 runs → job_ready_o=0 when queue_cnt_o=2; completions come out in order with ids 1,2,3.
- cmpl_ready_i held low 10 cycles → cmpl_valid_o and id/status stable; no bus activity for the next job until accepted.
- With SAURIA_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=64, done never asserted → completion status=1 after 64 cycles in WAIT_DONE. Reset asserted during CFG_REQ → all outputs 0 and queue_cnt_o=0.
